// File: rtl/sd_spi_shifter_pkg.sv
// Shared constants and FSM state type for the SD card SPI byte shifter.
package sd_spi_shifter_pkg;

  localparam logic [7:0] SPI_IDLE_BYTE  = 8'hFF;
  localparam int         SPI_HALF_TICKS = 16;
  localparam int         SPI_CNT_W      = 4;

  // Half-period count on which a byte completes.
  localparam logic [SPI_CNT_W-1:0] SPI_LAST_TICK = SPI_CNT_W'(SPI_HALF_TICKS - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 master byte shifter for the SD card port, with a one-entry
// pending slot so strobes arriving mid-transfer are queued instead of lost.
module sd_spi_shifter
  import sd_spi_shifter_pkg::*;
#(
  parameter bit IDLE_MOSI = 1'b1,
  parameter bit PENDING   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       tx,
  input  logic       rx,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       busy,
  output logic       done,
  output logic       ovr,
  input  logic       clr,
  output logic       ck,
  input  logic       miso,
  output logic       mosi
);

  state_e                 state_q, state_d;
  logic [SPI_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]             tx_sr_q, tx_sr_d;
  logic [7:0]             rx_sr_q, rx_sr_d;
  logic [7:0]             q_q, q_d;
  logic [7:0]             pend_byte_q, pend_byte_d;
  logic                   pend_full_q, pend_full_d;
  logic                   ck_q, ck_d;
  logic                   mosi_q, mosi_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;

  logic       strobe;
  logic [7:0] strobe_byte;
  logic       last_tick;
  logic       start;
  logic [7:0] start_byte;
  logic       ovr_set;

  // tx wins when both strobes arrive together.
  assign strobe      = tx | rx;
  assign strobe_byte = tx ? d : SPI_IDLE_BYTE;
  assign last_tick   = (state_q == S_SHIFT) && ce && (cnt_q == SPI_LAST_TICK);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    q_d         = q_q;
    pend_byte_d = pend_byte_q;
    pend_full_d = pend_full_q;
    ck_d        = ck_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;
    start       = 1'b0;
    start_byte  = SPI_IDLE_BYTE;
    ovr_set     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (strobe) begin
          start      = 1'b1;
          start_byte = strobe_byte;
        end
      end

      S_SHIFT: begin
        if (ce) begin
          cnt_d = cnt_q + 1'b1;
          if (!cnt_q[0]) begin
            ck_d    = 1'b1;
            rx_sr_d = {rx_sr_q[6:0], miso};
          end else begin
            ck_d = 1'b0;
            if (!last_tick) begin
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
              mosi_d  = tx_sr_q[6];
            end
          end
        end

        if (last_tick) begin
          q_d    = rx_sr_q;
          done_d = 1'b1;
          if (pend_full_q) begin
            start       = 1'b1;
            start_byte  = pend_byte_q;
            pend_full_d = 1'b0;
            ovr_set     = strobe;
          end else if (strobe) begin
            start      = 1'b1;
            start_byte = strobe_byte;
          end else begin
            state_d = S_IDLE;
            mosi_d  = IDLE_MOSI;
          end
        end else if (strobe) begin
          if (PENDING && !pend_full_q) begin
            pend_full_d = 1'b1;
            pend_byte_d = strobe_byte;
          end else begin
            ovr_set = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A new byte starts with its MSB on mosi; a ce on the start edge is not a tick.
    if (start) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      tx_sr_d = start_byte;
      mosi_d  = start_byte[7];
      ck_d    = 1'b0;
    end

    ovr_d = ovr_set | (ovr_q & ~clr);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      q_q         <= SPI_IDLE_BYTE;
      pend_byte_q <= '0;
      pend_full_q <= 1'b0;
      ck_q        <= 1'b0;
      mosi_q      <= IDLE_MOSI;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      q_q         <= q_d;
      pend_byte_q <= pend_byte_d;
      pend_full_q <= pend_full_d;
      ck_q        <= ck_d;
      mosi_q      <= mosi_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == S_SHIFT);
  assign done = done_q;
  assign ovr  = ovr_q;
  assign ck   = ck_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_sd_spi_shifter.sv
// Scoreboard bench for sd_spi_shifter: stimulus queues expected mosi/q bytes,
// a monitor assembles mosi at ck rising edges and checks them on each done.
module tb_sd_spi_shifter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce    = 1'b0;
  logic       tx    = 1'b0;
  logic       rx    = 1'b0;
  logic [7:0] d     = 8'h00;
  logic       clr   = 1'b0;
  logic       miso  = 1'b1;
  logic [7:0] q;
  logic       busy, done, ovr, ck, mosi;

  sd_spi_shifter #(.IDLE_MOSI(1'b1), .PENDING(1'b1)) dut (
    .clock(clock), .reset(reset), .ce(ce), .tx(tx), .rx(rx), .d(d),
    .q(q), .busy(busy), .done(done), .ovr(ovr), .clr(clr),
    .ck(ck), .miso(miso), .mosi(mosi)
  );

  typedef struct {
    logic [7:0] tx_b;
    logic [7:0] rx_b;
  } exp_t;

  exp_t       sb[$];
  int         done_cyc[$];
  int         cyc        = 0;
  int         done_count = 0;
  int         n_tests    = 0;
  int         n_fail     = 0;
  logic [7:0] slave_byte = 8'h00;

  initial forever #5 clock = ~clock;
  initial forever begin @(negedge clock); ce = ~ce; end
  initial forever begin @(posedge clock); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: shifts its byte out MSB first, advancing on each ck fall.
  initial begin
    logic [2:0] idx;
    logic       prev;
    idx  = '0;
    prev = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!reset) begin
        idx  = '0;
        prev = 1'b0;
      end else begin
        if (prev && !ck) idx = idx + 1'b1;
        prev = ck;
      end
      miso = slave_byte[3'd7 - idx];
    end
  end

  // Monitor: collects mosi at ck rises, checks against the scoreboard on done.
  initial begin
    logic [7:0] col;
    int         col_n;
    logic       prev_ck;
    exp_t       e;
    col = '0; col_n = 0; prev_ck = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        col_n   = 0;
        prev_ck = 1'b0;
      end else begin
        if (ck && !prev_ck) begin
          col = {col[6:0], mosi};
          col_n++;
        end
        prev_ck = ck;
        if (done) begin
          done_count++;
          done_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            check("mosi_byte", 32'(col), 32'(e.tx_b));
            check("q_byte", 32'(q), 32'(e.rx_b));
            check("ck_rises", 32'(col_n), 32'd8);
          end
          col_n = 0;
        end
      end
    end
  end

  // Issue a strobe on a posedge that also carries ce, so that ce must be ignored.
  task automatic strobe(input logic t, input logic r, input logic [7:0] data, output int t_cyc);
    @(negedge clock); #1;
    if (ce == 1'b0) begin @(negedge clock); #1; end
    tx = t; rx = r; d = data;
    @(posedge clock); #1;
    tx = 1'b0; rx = 1'b0;
    t_cyc = cyc;
  endtask

  task automatic wait_dones(input int target, input int budget, output int busy_low);
    int i;
    i = 0;
    busy_low = 0;
    while (done_count < target && i < budget) begin
      @(negedge clock); #2;
      i++;
      if (done_count < target && !busy) busy_low++;
    end
    check("done_wait_timeout", 32'(done_count >= target), 32'd1);
  endtask

  initial begin
    int t0, t1, t2, bl, base;

    repeat (3) @(negedge clock);
    check("rst_ck", 32'(ck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd1);
    check("rst_q", 32'(q), 32'hFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Plain tx byte.
    base = done_count;
    slave_byte = 8'h3C;
    sb.push_back('{tx_b: 8'hA5, rx_b: 8'h3C});
    strobe(1'b1, 1'b0, 8'hA5, t0);
    check("busy_after_strobe", 32'(busy), 32'd1);
    check("mosi_bit7_after_strobe", 32'(mosi), 32'd1);
    wait_dones(base + 1, 100, bl);
    check("tx_latency", 32'(done_cyc[done_cyc.size()-1] - t0), 32'd32);
    @(negedge clock);
    check("tx_busy_after", 32'(busy), 32'd0);
    check("tx_mosi_idle", 32'(mosi), 32'd1);

    // rx with miso held low.
    base = done_count;
    slave_byte = 8'h00;
    sb.push_back('{tx_b: 8'hFF, rx_b: 8'h00});
    strobe(1'b0, 1'b1, 8'h5A, t0);
    wait_dones(base + 1, 100, bl);
    repeat (40) @(negedge clock);
    check("rx_single_done", 32'(done_count), 32'(base + 1));
    check("rx_q_stable", 32'(q), 32'h00);

    // Second tx queued mid-transfer runs back-to-back.
    base = done_count;
    slave_byte = 8'h5A;
    sb.push_back('{tx_b: 8'h12, rx_b: 8'h5A});
    sb.push_back('{tx_b: 8'h34, rx_b: 8'h5A});
    strobe(1'b1, 1'b0, 8'h12, t0);
    repeat (8) @(negedge clock);
    strobe(1'b1, 1'b0, 8'h34, t1);
    wait_dones(base + 2, 200, bl);
    check("b2b_busy_gap", 32'(bl), 32'd0);
    check("b2b_first_latency", 32'(done_cyc[done_cyc.size()-2] - t0), 32'd32);
    check("b2b_spacing", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd32);
    check("b2b_ovr", 32'(ovr), 32'd0);

    // Three strobes in one byte time: the third is dropped.
    base = done_count;
    sb.push_back('{tx_b: 8'h11, rx_b: 8'h5A});
    sb.push_back('{tx_b: 8'h22, rx_b: 8'h5A});
    strobe(1'b1, 1'b0, 8'h11, t0);
    repeat (6) @(negedge clock);
    strobe(1'b1, 1'b0, 8'h22, t1);
    check("ovr_before_third", 32'(ovr), 32'd0);
    repeat (6) @(negedge clock);
    strobe(1'b1, 1'b0, 8'h33, t2);
    check("ovr_set", 32'(ovr), 32'd1);
    wait_dones(base + 2, 200, bl);
    repeat (40) @(negedge clock);
    check("ovr_two_dones", 32'(done_count), 32'(base + 2));
    check("ovr_sticky", 32'(ovr), 32'd1);
    @(negedge clock); clr = 1'b1;
    @(posedge clock); #1; clr = 1'b0;
    check("ovr_cleared", 32'(ovr), 32'd0);

    // tx and rx together: tx wins, no overrun.
    base = done_count;
    slave_byte = 8'hC3;
    sb.push_back('{tx_b: 8'h00, rx_b: 8'hC3});
    strobe(1'b1, 1'b1, 8'h00, t0);
    wait_dones(base + 1, 100, bl);
    check("txrx_ovr", 32'(ovr), 32'd0);
    check("txrx_latency", 32'(done_cyc[done_cyc.size()-1] - t0), 32'd32);

    // Reset mid-transfer aborts the byte without a done pulse.
    base = done_count;
    slave_byte = 8'h3C;
    strobe(1'b1, 1'b0, 8'hA5, t0);
    repeat (18) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_ck", 32'(ck), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q", 32'(q), 32'hFF);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("abort_no_done", 32'(done_count), 32'(base));

    base = done_count;
    slave_byte = 8'h69;
    sb.push_back('{tx_b: 8'h96, rx_b: 8'h69});
    strobe(1'b1, 1'b0, 8'h96, t0);
    wait_dones(base + 1, 100, bl);
    check("post_reset_latency", 32'(done_cyc[done_cyc.size()-1] - t0), 32'd32);

    repeat (4) @(negedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_spi_shifter.md
Name: sd_spi_shifter

Overview:
- Byte-wide SPI mode-0 master shift engine for the SD card interface.
- Sits directly downstream of the Z80 port decoder, which supplies one-cycle tx/rx strobes and the write data byte.
- Shifts one byte per strobe and holds the last received byte for IN reads.
- Adds a one-entry pending slot, so back-to-back OUT/IN strobes arriving during a transfer are queued rather than lost. Reports busy, done and overrun.

Parameters:
IDLE_MOSI, 1, level driven on mosi when no transfer is active.
PENDING, 1, 1 = one-entry pending slot enabled; 0 = strobes while busy are dropped and flagged.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ce     in  1  bit-rate enable; each high cycle is one SPI half-period tick
tx     in  1  one-cycle strobe: transmit d, capture miso
rx     in  1  one-cycle strobe: transmit 8'hFF, capture miso
d      in  8  transmit byte, sampled on the tx strobe cycle
q      out 8  last completed received byte
busy   out 1  transfer active or pending
done   out 1  one-cycle pulse when a byte completes
ovr    out 1  sticky overrun flag
clr    in  1  synchronous clear of ovr
ck     out 1  SPI clock, idle low
miso   in  1  SPI data in
mosi   out 1  SPI data out

Behaviour:
- Reset (asynchronous assert, synchronous release) forces:
  - ck=0, mosi=IDLE_MOSI, q=8'hFF, busy=0, done=0, ovr=0.
  - Pending slot empty, half-period counter 0.
  - A transfer in progress is aborted with no done pulse.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- Strobes are sampled on every clock edge, independent of ce.
- tx and rx high together: tx wins; rx is ignored without setting ovr.
- IDLE + strobe at edge T:
  - Load shift register with d (tx) or 8'hFF (rx); counter=0; go to SHIFT.
  - mosi = bit7 from T+1.
  - A ce on cycle T does not count as a tick.
- SHIFT, on each ce tick, with 4-bit counter n:
  - n even: ck<=1; sample miso into rx shift LSB.
  - n odd: ck<=0; present the next tx bit on mosi (skipped on n=15); n<=n+1.
  - Bits go out MSB first.
- Completion on tick n=15:
  - q<=received byte; done=1 for exactly that cycle; ck returns to 0.
  - Pending empty: go to IDLE; mosi=IDLE_MOSI next cycle.
  - Pending full: start the pending byte immediately with no idle gap; busy stays 1; mosi = its bit7 next cycle.
- Strobe while in SHIFT:
  - PENDING=1 and slot empty: store the byte (d or 8'hFF).
  - Slot full, or PENDING=0: strobe dropped; ovr<=1.
- Strobe on the completion edge itself:
  - Treated as a strobe in IDLE if the slot is empty, so that byte starts next.
  - If the slot is full, that strobe is dropped and ovr is set.
- ovr stays set until clr; set wins over clr on the same cycle.
- q changes only on completion edges; it is stable between them.
- Byte time: 16 ce ticks after the strobe edge. With ce every 2 clocks, done arrives 32 clocks after the strobe.

Decomposition:
- Shared package: SPI_IDLE_BYTE = 8'hFF, SPI_HALF_TICKS = 16, counter width 4, FSM state enum {S_IDLE, S_SHIFT}.
- Single module; the pending slot and FSM are too small to warrant a sub-module.
- The ce generator lives outside this block.

Test Plan:
- tx d=8'hA5, miso slave byte 8'h3C, ce every 2 clocks -> mosi 1,0,1,0,0,1,0,1; 8 ck rising edges; done at strobe+32; q=8'h3C; busy low afterwards.
- rx strobe, miso held 0 -> mosi high for all 8 bits; q=8'h00; done pulse once.
- tx 8'h12, then tx 8'h34 at tick 5 -> second byte starts on the completion edge with no gap; busy high continuously; two done pulses 32 clocks apart; ovr=0.
- Three tx strobes inside one byte time -> third dropped; ovr=1; ovr cleared by clr; only two done pulses.
- tx and rx strobed together with d=8'h00 -> mosi all 0 (tx wins); ovr=0.
- reset asserted at tick 9 -> immediately ck=0, mosi=1, busy=0, q=8'hFF; no done pulse; next strobe after release runs a normal byte.
